fb_write_arbiter: RTL and testbench
===================================

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter FB_WORDS, default 34240 (214x160): number of framebuffer words.
REQ-002 Parameter A_WIDTH, default 16: framebuffer address width.
REQ-003 Parameter D_WIDTH, default 3: pixel width (R,G,B bits).
REQ-004 clk  in  1: single clock (50 MHz domain); all logic SHALL be clocked on its rising edge.
REQ-005 n_rst_async  in  1: reset, asynchronous assert, active-low.
REQ-006 gpu_req  in  1: rasterizer write request; gpu_addr  in  A_WIDTH; gpu_pixel  in  D_WIDTH.
REQ-007 gpu_gnt  out  1: rasterizer request accepted this cycle.
REQ-008 cpu_req  in  1: CPU direct-pixel write request; cpu_addr  in  A_WIDTH; cpu_pixel  in  D_WIDTH.
REQ-009 cpu_gnt  out  1: CPU request accepted this cycle.
REQ-010 clear_start  in  1: start full-screen fill; clear_colour  in  D_WIDTH: fill pixel.
REQ-011 clear_busy  out  1: fill in progress; clear_done  out  1: one-cycle completion pulse.
REQ-012 fb_addr  out  A_WIDTH; fb_write_en  out  1; fb_pixel  out  D_WIDTH: framebuffer write port B.

Function
REQ-013 State machine SHALL have two states, IDLE and CLEAR.
REQ-014 IDLE: gpu_gnt/cpu_gnt SHALL be combinational from req and the round-robin pointer; at most one SHALL be high per cycle.
REQ-015 Single requester SHALL be granted the same cycle; both requesting SHALL grant the one not granted most recently.
REQ-016 Round-robin pointer SHALL update only on a grant; after reset the GPU SHALL win the first contention.
REQ-017 Granted addr/pixel SHALL appear on fb_addr/fb_pixel with fb_write_en=1 exactly one cycle after the grant (registered outputs, latency 1).
REQ-018 Granted address >= FB_WORDS SHALL be consumed (gnt high) but produce fb_write_en=0 the next cycle.
REQ-019 No grant in a cycle SHALL give fb_write_en=0 next cycle; fb_addr/fb_pixel SHALL hold their last value.
REQ-020 clear_start in IDLE SHALL latch clear_colour and enter CLEAR at the next edge; grants in that same cycle SHALL still be honoured.
REQ-021 CLEAR: gpu_gnt=cpu_gnt=0, clear_busy=1; fb_addr SHALL step 0,1,...,FB_WORDS-1 one per cycle with fb_write_en=1 and the latched colour.
REQ-022 The cycle fb_addr=FB_WORDS-1 is presented, clear_done SHALL be 1; next edge SHALL return to IDLE with clear_busy=0.
REQ-023 clear_start while in CLEAR SHALL be ignored (no restart, colour unchanged).
REQ-024 Fill SHALL take exactly FB_WORDS write cycles; address counter SHALL NOT wrap past FB_WORDS-1.
REQ-025 Requests held during CLEAR SHALL be granted per REQ-015 on the first IDLE cycle.

Reset
REQ-026 On n_rst_async low: state IDLE, fb_write_en=0, fb_addr=0, fb_pixel=0, clear_busy=0, clear_done=0, gnts=0, pointer=CPU-last, counter=0.
REQ-027 Reset during CLEAR SHALL abort the fill immediately; no further writes until a new clear_start.
REQ-028 Deassertion SHALL be synchronised to clk before state leaves reset values.

Structure
REQ-029 Shared package vgacpu_pkg SHALL hold FB_WIDTH=214, FB_HEIGHT=160, FB_WORDS, FB_A_WIDTH, pixel_t (D_WIDTH bits) and the arbiter state enum.
REQ-030 No sub-module; arbiter, fill counter and output registers SHALL live in fb_write_arbiter.

Verification
REQ-031 GPU-only req addr 0x0010 pixel 3'b101 -> gpu_gnt same cycle; next cycle fb_write_en=1, fb_addr=0x0010, fb_pixel=3'b101.
REQ-032 Both req continuously after reset -> grants GPU,CPU,GPU,CPU...; writes follow one cycle later in same order.
REQ-033 CPU req addr 34240 -> cpu_gnt=1, next cycle fb_write_en=0.
REQ-034 clear_start colour 3'b010 -> 34240 consecutive writes addr 0..34239 pixel 3'b010; clear_done high with addr 34239; gnts 0 throughout.
REQ-035 Second clear_start at fill addr 100 -> ignored, fill completes unchanged; GPU req held during fill granted first IDLE cycle.
REQ-036 Reset asserted at fill addr 500 -> fb_write_en=0 immediately, clear_busy=0, no writes after release.

Source files
------------

// File: rtl/vgacpu_pkg.sv
// Shared framebuffer geometry and types for the VGA/CPU video subsystem.
package vgacpu_pkg;

  localparam int FB_WIDTH   = 214;
  localparam int FB_HEIGHT  = 160;
  localparam int FB_WORDS   = FB_WIDTH * FB_HEIGHT;
  localparam int FB_A_WIDTH = 16;
  localparam int PIXEL_W    = 3;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_CLEAR = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fb_write_arbiter.sv
// Framebuffer port-B write arbiter: round-robin between rasterizer and CPU,
// plus a full-screen fill engine that owns the port while clearing.
module fb_write_arbiter #(
  parameter int FB_WORDS = vgacpu_pkg::FB_WORDS,
  parameter int A_WIDTH  = vgacpu_pkg::FB_A_WIDTH,
  parameter int D_WIDTH  = vgacpu_pkg::PIXEL_W
) (
  input  logic               clk,
  input  logic               n_rst_async,
  input  logic               gpu_req,
  input  logic [A_WIDTH-1:0] gpu_addr,
  input  logic [D_WIDTH-1:0] gpu_pixel,
  output logic               gpu_gnt,
  input  logic               cpu_req,
  input  logic [A_WIDTH-1:0] cpu_addr,
  input  logic [D_WIDTH-1:0] cpu_pixel,
  output logic               cpu_gnt,
  input  logic               clear_start,
  input  logic [D_WIDTH-1:0] clear_colour,
  output logic               clear_busy,
  output logic               clear_done,
  output logic [A_WIDTH-1:0] fb_addr,
  output logic               fb_write_en,
  output logic [D_WIDTH-1:0] fb_pixel
);

  import vgacpu_pkg::*;

  localparam logic [A_WIDTH:0]   WORDS_EXT = (A_WIDTH+1)'(FB_WORDS);
  localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(FB_WORDS - 1);

  arb_state_t         state;
  logic [1:0]         rst_sync;
  logic               rst_n;
  logic               cpu_last;
  logic [A_WIDTH-1:0] fill_count;
  logic [D_WIDTH-1:0] fill_colour;
  logic               gpu_in_range;
  logic               cpu_in_range;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge n_rst_async) begin
    if (!n_rst_async) rst_sync <= 2'b00;
    else              rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  assign gpu_in_range = ({1'b0, gpu_addr} < WORDS_EXT);
  assign cpu_in_range = ({1'b0, cpu_addr} < WORDS_EXT);

  // On contention the side that did not win last time gets the port.
  always_comb begin
    gpu_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (rst_n && state == ARB_IDLE) begin
      if (gpu_req && cpu_req) begin
        gpu_gnt = cpu_last;
        cpu_gnt = !cpu_last;
      end else begin
        gpu_gnt = gpu_req;
        cpu_gnt = cpu_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      fb_addr     <= '0;
      fb_pixel    <= '0;
      fb_write_en <= 1'b0;
      clear_busy  <= 1'b0;
      clear_done  <= 1'b0;
      cpu_last    <= 1'b1;
      fill_count  <= '0;
      fill_colour <= '0;
    end else begin
      fb_write_en <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (gpu_gnt) begin
            cpu_last <= 1'b0;
            if (gpu_in_range) begin
              fb_addr     <= gpu_addr;
              fb_pixel    <= gpu_pixel;
              fb_write_en <= 1'b1;
            end
          end else if (cpu_gnt) begin
            cpu_last <= 1'b1;
            if (cpu_in_range) begin
              fb_addr     <= cpu_addr;
              fb_pixel    <= cpu_pixel;
              fb_write_en <= 1'b1;
            end
          end
          if (clear_start) begin
            state       <= ARB_CLEAR;
            fill_colour <= clear_colour;
            fill_count  <= '0;
            clear_busy  <= 1'b1;
          end
        end

        // The done pulse is shown alongside the last address; the cycle after it we hand the port back.
        ARB_CLEAR: begin
          if (clear_done) begin
            state      <= ARB_IDLE;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
          end else begin
            fb_addr     <= fill_count;
            fb_pixel    <= fill_colour;
            fb_write_en <= 1'b1;
            if (fill_count == LAST_ADDR) clear_done <= 1'b1;
            else                         fill_count <= fill_count + A_WIDTH'(1);
          end
        end

        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: vector table with a write scoreboard,
// then hand-written fill, fill-restart and reset-during-fill sequences.
module tb_fb_write_arbiter;

  import vgacpu_pkg::*;

  localparam int N  = 34240;
  localparam int AW = 16;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          n_rst_async = 1'b0;
  logic          gpu_req = 1'b0, cpu_req = 1'b0, clear_start = 1'b0;
  logic [AW-1:0] gpu_addr = '0, cpu_addr = '0;
  logic [DW-1:0] gpu_pixel = '0, cpu_pixel = '0, clear_colour = '0;
  logic          gpu_gnt, cpu_gnt, clear_busy, clear_done, fb_write_en;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_pixel;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic          gr;
    logic [AW-1:0] ga;
    logic [DW-1:0] gp;
    logic          cr;
    logic [AW-1:0] ca;
    logic [DW-1:0] cp;
    logic          eg;
    logic          ec;
  } vec_t;

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] pix;
    logic          chk_addr;
  } wr_t;

  vec_t          vecs[15];
  wr_t           exp_q[$];
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_pix = '0;

  fb_write_arbiter dut (
    .clk(clk), .n_rst_async(n_rst_async),
    .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_pixel(gpu_pixel), .gpu_gnt(gpu_gnt),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_pixel(cpu_pixel), .cpu_gnt(cpu_gnt),
    .clear_start(clear_start), .clear_colour(clear_colour),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .fb_addr(fb_addr), .fb_write_en(fb_write_en), .fb_pixel(fb_pixel)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Expected write for a grant, as the framebuffer port should show it one cycle later.
  task automatic push_expected(input logic g, input logic c,
                               input logic [AW-1:0] ga, input logic [DW-1:0] gp,
                               input logic [AW-1:0] ca, input logic [DW-1:0] cp);
    wr_t w;
    logic [AW-1:0] a;
    logic [DW-1:0] p;
    a = g ? ga : ca;
    p = g ? gp : cp;
    if ((g || c) && int'(a) < N) begin
      last_addr = a;
      last_pix  = p;
      w = '{1'b1, a, p, 1'b1};
    end else begin
      w = '{1'b0, last_addr, last_pix, !(g || c)};
    end
    exp_q.push_back(w);
  endtask

  task automatic drain_write(input string tag);
    wr_t w;
    if (exp_q.size() == 0) return;
    w = exp_q.pop_front();
    check_output({tag, " wr_en"}, 32'(fb_write_en), 32'(w.en));
    if (w.en || w.chk_addr) begin
      check_output({tag, " addr"}, 32'(fb_addr), 32'(w.addr));
      check_output({tag, " pixel"}, 32'(fb_pixel), 32'(w.pix));
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    gpu_req = v.gr; gpu_addr = v.ga; gpu_pixel = v.gp;
    cpu_req = v.cr; cpu_addr = v.ca; cpu_pixel = v.cp;
    #1;
    check_output($sformatf("vec%0d gpu_gnt", idx), 32'(gpu_gnt), 32'(v.eg));
    check_output($sformatf("vec%0d cpu_gnt", idx), 32'(cpu_gnt), 32'(v.ec));
    push_expected(v.eg, v.ec, v.ga, v.gp, v.ca, v.cp);
  endtask

  initial begin
    bit aborted;
    int writes;
    bit found;

    vecs[0]  = '{1'b1, 16'h0100, 3'd1, 1'b1, 16'h0200, 3'd2, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 16'h0101, 3'd3, 1'b1, 16'h0201, 3'd4, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 16'h0102, 3'd5, 1'b1, 16'h0202, 3'd6, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 16'h0103, 3'd7, 1'b1, 16'h0203, 3'd0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 16'h0010, 3'b101, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 16'h0000, 3'd0, 1'b1, 16'h1234, 3'd6, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 16'h0000, 3'd0, 1'b1, 16'h85C0, 3'd1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 16'h0005, 3'd2, 1'b1, 16'h0006, 3'd3, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 16'h85BF, 3'd4, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 16'hFFFF, 3'd7, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 16'h0007, 3'd1, 1'b1, 16'h0008, 3'd2, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 16'h0000, 3'd0, 1'b1, 16'h0009, 3'd3, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 16'h000A, 3'd4, 1'b1, 16'h000B, 3'd5, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};

    // Reset values, with requests asserted to show grants are suppressed.
    gpu_req = 1'b1; cpu_req = 1'b1;
    repeat (2) @(negedge clk);
    check_output("rst gnts", 32'({gpu_gnt, cpu_gnt}), 32'h0);
    check_output("rst wr_en", 32'(fb_write_en), 32'h0);
    check_output("rst addr", 32'(fb_addr), 32'h0);
    check_output("rst pixel", 32'(fb_pixel), 32'h0);
    check_output("rst busy/done", 32'({clear_busy, clear_done}), 32'h0);

    n_rst_async = 1'b1;
    cpu_req = 1'b0;
    #1;
    check_output("rst release sync gnt", 32'(gpu_gnt), 32'h0);
    gpu_req = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drain_write($sformatf("wr%0d", i - 1));
      apply_stimulus(vecs[i], i);
    end
    @(negedge clk);
    drain_write("wr14");

    // Fill with colour 2; a GPU write granted in the start cycle still lands.
    clear_start = 1'b1; clear_colour = 3'b010;
    gpu_req = 1'b1; gpu_addr = 16'h0020; gpu_pixel = 3'd6;
    #1;
    check_output("start gpu_gnt", 32'({gpu_gnt, cpu_gnt}), 32'h2);
    push_expected(1'b1, 1'b0, 16'h0020, 3'd6, 16'h0, 3'd0);
    @(negedge clk);
    drain_write("start");
    check_output("start busy/done", 32'({clear_busy, clear_done}), 32'h2);
    clear_start = 1'b0;
    gpu_addr = 16'h0030; gpu_pixel = 3'd1;

    aborted = 1'b0;
    for (int i = 0; i < N; i++) begin
      logic [23:0] act, req;
      @(negedge clk);
      act = {clear_busy, fb_write_en, fb_addr, fb_pixel, clear_done, gpu_gnt, cpu_gnt};
      req = {1'b1, 1'b1, AW'(i), 3'b010, (i == N - 1), 1'b0, 1'b0};
      check_output($sformatf("fill@%0d", i), 32'(act), 32'(req));
      if (act !== req) begin
        aborted = 1'b1;
        break;
      end
      if (i == 100) begin
        clear_start = 1'b1; clear_colour = 3'b111;
      end else begin
        clear_start = 1'b0;
      end
    end
    clear_start = 1'b0;

    if (aborted) begin
      found = 1'b0;
      for (int k = 0; k < N + 10; k++) begin
        @(negedge clk);
        if (!clear_busy) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL fill_end_timeout: clear_busy still 1, required 0");
      end
      gpu_req = 1'b0;
      exp_q.delete();
    end else begin
      @(negedge clk);
      check_output("post-fill busy/done/wr_en", 32'({clear_busy, clear_done, fb_write_en}), 32'h0);
      check_output("post-fill held gpu_gnt", 32'({gpu_gnt, cpu_gnt}), 32'h2);
      push_expected(1'b1, 1'b0, 16'h0030, 3'd1, 16'h0, 3'd0);
      @(negedge clk);
      gpu_req = 1'b0;
      drain_write("post-fill");
    end

    // Reset in the middle of a fill aborts it on the spot.
    @(negedge clk);
    clear_start = 1'b1; clear_colour = 3'b011;
    @(negedge clk);
    clear_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (fb_write_en && fb_addr == 16'd500) begin
        found = 1'b1;
        break;
      end
    end
    check_output("reached fill addr 500", 32'(found), 32'h1);
    check_output("fill pixel @500", 32'(fb_pixel), 32'h3);
    #1 n_rst_async = 1'b0;
    #1;
    check_output("abort wr_en/busy/done", 32'({fb_write_en, clear_busy, clear_done}), 32'h0);
    repeat (2) @(negedge clk);
    n_rst_async = 1'b1;
    writes = 0;
    repeat (40) begin
      @(negedge clk);
      if (fb_write_en || clear_busy) writes++;
    end
    check_output("writes after reset", 32'(writes), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
